// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU front end.
//   ADDR_W / INSTR_W : byte-address and instruction widths
//   RESET_PC         : default first fetch address after reset
//   fetch_entry_t    : one buffered fetch result {pc, instr}
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t holding returned instructions for decode.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears storage)
//   push       : write push_data at the tail
//   pop        : remove the head; ignored when empty
//   flush      : empty the FIFO; wins over push and pop
//   push_data  : entry to write
//   head       : entry at the head (registered storage, no input bypass)
//   count      : number of valid entries
//   not_empty  : head is valid
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] push_data,
    output logic [ENTRY_W-1:0] head,
    output logic [CNT_W-1:0]   count,
    output logic               not_empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The fetch credit scheme guarantees this never fires; a push into a
    // full FIFO is only legal when the head leaves in the same cycle.
    overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && !do_pop && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, drives the instruction-memory
// read port, tags the single in-flight read and buffers results for decode.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   redirect_valid  : flush all wrong-path work, restart at redirect_pc
//   redirect_pc     : restart byte address (bit 0 ignored)
//   halt            : level; blocks new fetches without flushing
//   mem_raddr       : instruction-memory word address, data next cycle
//   mem_rdata       : instruction for the previous cycle's address
//   out_valid/out_pc/out_instr : FIFO head towards decode
//   out_ready       : decode accepts the head this cycle
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt,
    output logic [ADDR_W-2:0]   mem_raddr,
    input  logic [INSTR_W-1:0]  mem_rdata,
    output logic                out_valid,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [INSTR_W-1:0]  out_instr,
    input  logic                out_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              req_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue;
    logic              pop;
    logic              push;
    logic [CNT_W-1:0]  count;
    logic [SUM_W-1:0]  outstanding;
    logic [SUM_W-1:0]  credit_limit;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              unused_redirect_bit;

    assign unused_redirect_bit = redirect_pc[0];

    assign issue_addr = redirect_valid ? {redirect_pc[ADDR_W-1:1], 1'b0} : fetch_pc;
    assign mem_raddr  = issue_addr[ADDR_W-1:1];

    assign pop = out_valid && out_ready;

    // Credit: buffered + in-flight entries, minus the one leaving this cycle,
    // must stay below DEPTH. A redirect wipes both the FIFO and the in-flight
    // read, and its same-cycle pop is discarded, so everything counts as zero.
    // The pop is added to the limit rather than subtracted to avoid underflow.
    assign outstanding  = redirect_valid ? '0
                        : SUM_W'(count) + SUM_W'(req_valid);
    assign credit_limit = SUM_W'(DEPTH) + SUM_W'(pop && !redirect_valid);
    assign issue        = !halt && (outstanding < credit_limit);

    assign push       = req_valid && !redirect_valid;
    assign push_entry = '{pc: req_pc, instr: mem_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            req_valid <= 1'b0;
            req_pc    <= '0;
        end else begin
            req_valid <= issue;
            if (issue) begin
                req_pc   <= issue_addr;
                fetch_pc <= issue_addr + ADDR_W'(2);
            end else begin
                fetch_pc <= issue_addr;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head      (head),
        .count     (count),
        .not_empty (out_valid)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic        out_ready;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];

    fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    // Instruction memory: word n holds 16'h8000 + n, one-cycle read latency.
    always @(posedge clk) mem_rdata <= 16'h8000 + {1'b0, mem_raddr};

    function automatic logic [15:0] instr_of(input logic [15:0] pc);
        return 16'h8000 + {1'b0, pc[15:1]};
    endfunction

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        halt = 1'b0; out_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", out_pc); end
        total++; if (out_instr !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", out_instr); end
        total++; if (mem_raddr !== 15'h0000) begin bad++; $display("FAIL reset_raddr: got %h want 0000", mem_raddr); end
        reset = 1'b0; out_ready = 1'b0;
        @(negedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early: got valid=%b want 0", out_valid); end
        @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instr !== 16'h8000) begin
            bad++; $display("FAIL latency_first: got v=%b pc=%h instr=%h want v=1 pc=0000 instr=8000",
                            out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_stream;
        logic [15:0] e;
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back(16'(2 * i));
        for (int c = 0; c < 9; c++) begin
            @(negedge clk); #1;
            if (c >= 1) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_bubble: cycle %0d valid=%b want 1", c, out_valid); end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got pc=%h, none expected", out_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (out_pc !== e || out_instr !== instr_of(e)) begin
                        bad++; $display("FAIL stream_order: got pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, e, instr_of(e));
                    end
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_missing: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        logic [15:0] e;
        do_reset(1'b0);
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            out_ready = (c >= 10);
            #1;
            if (c == 9) begin
                total++; if (mem_raddr !== 15'h0004) begin bad++; $display("FAIL bp_raddr: got %h want 0004", mem_raddr); end
                total++;
                if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instr !== 16'h8000) begin
                    bad++; $display("FAIL bp_hold: got v=%b pc=%h instr=%h want v=1 pc=0000 instr=8000", out_valid, out_pc, out_instr);
                end
                for (int i = 0; i < 9; i++) exp_q.push_back(16'(2 * i));
            end
            if (c >= 10) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_gap: cycle %0d valid=%b want 1", c, out_valid); end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra: got pc=%h, none expected", out_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (out_pc !== e || out_instr !== instr_of(e)) begin
                        bad++; $display("FAIL bp_order: got pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, e, instr_of(e));
                    end
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_missing: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_redirect;
        logic [15:0] e;
        do_reset(1'b1);
        exp_q.push_back(16'h0000); exp_q.push_back(16'h0002); exp_q.push_back(16'h0004);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            out_ready      = (c <= 3) || (c >= 8);
            redirect_valid = (c == 8);
            redirect_pc    = 16'h0041;
            #1;
            if (c == 7) begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== 16'h0006 || mem_raddr !== 15'h0007) begin
                    bad++; $display("FAIL redir_fill: got v=%b pc=%h raddr=%h want v=1 pc=0006 raddr=0007", out_valid, out_pc, mem_raddr);
                end
            end
            if (c == 8) begin
                total++; if (mem_raddr !== 15'h0020) begin bad++; $display("FAIL redir_raddr: got %h want 0020", mem_raddr); end
                for (int i = 0; i < 8; i++) exp_q.push_back(16'h0040 + 16'(2 * i));
            end
            if (c == 9) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got valid=%b want 0", out_valid); end
            end
            if (c != 8 && out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL redir_extra: got pc=%h, none expected", out_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (out_pc !== e || out_instr !== instr_of(e)) begin
                        bad++; $display("FAIL redir_order: got pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, e, instr_of(e));
                    end
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL redir_missing: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_halt;
        logic [15:0] e;
        do_reset(1'b1);
        for (int i = 0; i < 15; i++) exp_q.push_back(16'(2 * i));
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            halt = (c >= 4) && (c <= 8);
            #1;
            if (c == 8) begin
                total++; if (mem_raddr !== 15'h0005) begin bad++; $display("FAIL halt_raddr: got %h want 0005", mem_raddr); end
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL halt_drain: got valid=%b want 0", out_valid); end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL halt_extra: got pc=%h, none expected", out_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (out_pc !== e || out_instr !== instr_of(e)) begin
                        bad++; $display("FAIL halt_order: got pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, e, instr_of(e));
                    end
                end
            end
        end
        halt = 1'b0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL halt_missing: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_wrap;
        logic [15:0] e;
        do_reset(1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            redirect_valid = (c == 0);
            redirect_pc    = 16'hFFFC;
            #1;
            if (c == 0) begin
                exp_q.push_back(16'hFFFC); exp_q.push_back(16'hFFFE);
                exp_q.push_back(16'h0000); exp_q.push_back(16'h0002);
            end
            if (c == 1) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_flush: got valid=%b want 0", out_valid); end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL wrap_extra: got pc=%h, none expected", out_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (out_pc !== e || out_instr !== instr_of(e)) begin
                        bad++; $display("FAIL wrap_order: got pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, e, instr_of(e));
                    end
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_missing: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_override;
        logic [15:0] e;
        do_reset(1'b0);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            reset          = (c == 8);
            redirect_valid = (c == 8);
            redirect_pc    = 16'h1234;
            halt           = (c == 8);
            out_ready      = (c >= 9);
            #1;
            if (c == 7) begin
                total++;
                if (out_valid !== 1'b1 || mem_raddr !== 15'h0004) begin
                    bad++; $display("FAIL rstov_full: got v=%b raddr=%h want v=1 raddr=0004", out_valid, mem_raddr);
                end
            end
            if (c == 9) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstov_valid: got %b want 0", out_valid); end
                total++; if (mem_raddr !== 15'h0000) begin bad++; $display("FAIL rstov_raddr: got %h want 0000", mem_raddr); end
                for (int i = 0; i < 4; i++) exp_q.push_back(16'(2 * i));
            end
            if (c >= 9 && out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL rstov_extra: got pc=%h, none expected", out_pc); end
                else begin
                    e = exp_q.pop_front();
                    if (out_pc !== e || out_instr !== instr_of(e)) begin
                        bad++; $display("FAIL rstov_order: got pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, e, instr_of(e));
                    end
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rstov_missing: %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        halt = 1'b0; out_ready = 1'b0;
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect;
        test_halt;
        test_wrap;
        test_reset_override;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the 16-bit pipelined CPU. Owns the PC and drives the instruction-memory read port. Tags the single in-flight read and buffers returned instructions with their PCs in a small FIFO, which decode drains through a valid/ready handshake. A writeback redirect flushes all wrong-path work and restarts fetch at the target with no bubble.

## Interface
Parameters:
- DEPTH, 4, fetch FIFO entries (power of two, ≥2)
- RESET_PC, 16'h0000, first fetch address after reset

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous active-high reset
- redirect_valid  in  1  flush and restart fetch (taken jump / misprediction from writeback)
- redirect_pc  in  16  restart byte address; bit 0 ignored
- halt  in  1  level; while high no new fetches issue
- mem_raddr  out  15  instruction-memory word address (byte PC[15:1]), data returns next cycle
- mem_rdata  in  16  instruction for the address presented in the previous cycle
- out_valid  out  1  FIFO head holds a valid instruction
- out_pc  out  16  byte PC of the head instruction
- out_instr  out  16  head instruction word
- out_ready  in  1  decode accepts head this cycle (pop = out_valid & out_ready)

## Operation
- State: fetch_pc, req_valid/req_pc (one in-flight read), FIFO of {pc, instr}, count.
- Issue address: redirect_valid ? redirect_pc&~1 : fetch_pc; mem_raddr = issue_addr[15:1], driven every cycle.
- issue = !halt & (count_after_flush + req_valid_after_flush − pop < DEPTH). After a redirect, count and req_valid both count as 0.
- On issue: req_valid<=1, req_pc<=issue_addr, fetch_pc<=issue_addr+2, wrapping 16'hFFFE→16'h0000. No issue: req_valid<=0, fetch_pc<=issue_addr.
- Response: if req_valid & !redirect_valid, push {req_pc, mem_rdata} to FIFO tail.
- redirect_valid: FIFO emptied (count<=0; the pop that cycle is discarded), in-flight response dropped, new fetch from redirect_pc issues the same cycle (unless halt).
- Simultaneous push and pop when full are legal and leave count unchanged. The credit rule makes overflow impossible. A push into a full FIFO is an assertion failure.
- Pop when empty is ignored.
- halt does not flush: in-flight read completes and the FIFO drains normally. Fetch resumes from fetch_pc when halt drops.
- reset: fetch_pc=RESET_PC, req_valid=0, count=0, FIFO storage=0. Therefore out_valid=0, out_pc=0, out_instr=0, mem_raddr=RESET_PC[15:1]. reset overrides redirect_valid and halt.

## Timing
- Latency: address issued in cycle t → mem_rdata in t+1 → visible at FIFO head (out_valid) in t+2.
- Throughput: one instruction/cycle sustained while out_ready=1, for any DEPTH≥2.
- out_valid, out_pc and out_instr come straight from registers; no combinational path from mem_rdata.
- out_ready→issue path is combinational (credit uses pop); out_ready does not reach mem_raddr.
- Redirect in cycle t: out_valid=0 in t+1; first redirected instruction at head in t+2.
- Backpressure: with out_ready=0, at most DEPTH instructions are buffered/in flight. Issue stops the cycle count+req_valid reaches DEPTH.

## Structure
- Shared package cpu_pkg:
  - ADDR_W=16, INSTR_W=16, RESET_PC default
  - typedef fetch_entry_t {pc, instr}
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush and count; flush has priority over push and pop.
- fetch_unit holds the PC, in-flight tag, credit logic and redirect muxing.

## Test plan
- Reset then out_ready=1, memory word n = 16'h8000+n:
  - (out_pc, out_instr) = (0,8000),(2,8001),(4,8002)… one per cycle.
  - First out_valid two cycles after reset deasserts.
- out_ready=0 for 10 cycles:
  - issues stop after 4 outstanding; out_pc holds 0 and mem_raddr stops advancing.
  - Release → pcs 0,2,4,6,8 in order with no gap or duplicate.
- redirect_valid with redirect_pc=16'h0041 while FIFO holds pcs 6..C:
  - next cycle out_valid=0
  - then pcs 0x40, 0x42… (bit 0 dropped); no stale pc appears.
- halt high for 5 cycles mid-stream:
  - in-flight instruction still delivered, no new addresses consumed.
  - After halt drops, pcs continue contiguously.
- Redirect to 16'hFFFC: delivered pcs FFFC, FFFE, 0000, 0002.
- reset asserted with redirect_valid=1 and a full FIFO:
  - next cycle out_valid=0, mem_raddr=0
  - fetch restarts from RESET_PC.
